mux_rr_scheduler: RTL and testbench

//  Round-robin scheduler for a 3-source (alpha/beta/gamma) 8-bit output mux.

---
 rtl/mux_rr_scheduler_if.sv | 26 ++
 rtl/mux_rr_scheduler.sv | 145 ++++++++++++++
 tb/tb_mux_rr_scheduler.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mux_rr_scheduler_if.sv
// Bus bundle between the three producers, the round-robin scheduler and the shared consumer.
interface mux_rr_scheduler_if #(
    parameter int unsigned WIDTH = 8
);
    logic [2:0]       req;
    logic [WIDTH-1:0] alpha;
    logic [WIDTH-1:0] beta;
    logic [WIDTH-1:0] gamma;
    logic [2:0]       ack;
    logic [1:0]       sel;
    logic             cs;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             out_ready;
    logic [47:0]      grant_cnt;

    modport slave (
        input  req, alpha, beta, gamma, out_ready,
        output ack, sel, cs, out, out_valid, grant_cnt
    );

    modport master (
        output req, alpha, beta, gamma, out_ready,
        input  ack, sel, cs, out, out_valid, grant_cnt
    );
endinterface

// File: rtl/mux_rr_scheduler.sv
// Round-robin burst scheduler muxing alpha/beta/gamma onto one valid/ready output.
// Optional per-source grant counters enabled by defining MUX_SCHED_STATS_EN.
module mux_rr_scheduler #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic                clk,
    input  logic                nreset,
    mux_rr_scheduler_if.slave   bus
);
    localparam int unsigned BEATS_W = $clog2(BURST_MAX + 1);
    localparam int unsigned CNT_W   = 16;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             r_state, w_state_nxt;
    logic [1:0]         r_ptr, w_ptr_nxt;
    logic [1:0]         r_sel, w_sel_nxt;
    logic [BEATS_W-1:0] r_beats, w_beats_nxt;
    logic               r_cs, w_cs_nxt;
    logic [WIDTH-1:0]   r_out, w_out_nxt;
    logic               r_out_valid, w_out_valid_nxt;
    logic [2:0]         w_ack;
    logic [1:0]         w_pick;
    logic               w_pick_ok;
    logic [1:0]         w_ptr_p1;
    logic [1:0]         w_ptr_p2;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    function automatic logic [WIDTH-1:0] src_data(input logic [1:0] idx,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [WIDTH-1:0] g);
        case (idx)
            2'd0:    return a;
            2'd1:    return b;
            default: return g;
        endcase
    endfunction

    // Rotating priority: ptr first, then ptr+1, then ptr+2 (mod 3)
    always_comb begin
        w_ptr_p1  = inc3(r_ptr);
        w_ptr_p2  = inc3(w_ptr_p1);
        w_pick    = r_ptr;
        w_pick_ok = 1'b1;
        if (bus.req[r_ptr])         w_pick = r_ptr;
        else if (bus.req[w_ptr_p1]) w_pick = w_ptr_p1;
        else if (bus.req[w_ptr_p2]) w_pick = w_ptr_p2;
        else                        w_pick_ok = 1'b0;
    end

    // Next-state and ack; ack is suppressed while reset is asserted
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_sel_nxt       = r_sel;
        w_beats_nxt     = r_beats;
        w_cs_nxt        = r_cs;
        w_out_nxt       = r_out;
        w_out_valid_nxt = r_out_valid;
        w_ack           = 3'b000;
        case (r_state)
            IDLE: begin
                w_cs_nxt        = 1'b0;
                w_out_valid_nxt = 1'b0;
                if (w_pick_ok) begin
                    w_ack           = 3'b001 << w_pick;
                    w_out_nxt       = src_data(w_pick, bus.alpha, bus.beta, bus.gamma);
                    w_out_valid_nxt = 1'b1;
                    w_cs_nxt        = 1'b1;
                    w_sel_nxt       = w_pick;
                    w_beats_nxt     = BEATS_W'(1);
                    w_state_nxt     = BUSY;
                end
            end
            BUSY: begin
                if (r_out_valid && bus.out_ready) begin
                    if (bus.req[r_sel] && (r_beats < BEATS_W'(BURST_MAX))) begin
                        w_ack       = 3'b001 << r_sel;
                        w_out_nxt   = src_data(r_sel, bus.alpha, bus.beta, bus.gamma);
                        w_beats_nxt = r_beats + BEATS_W'(1);
                    end else begin
                        w_out_valid_nxt = 1'b0;
                        w_cs_nxt        = 1'b0;
                        w_ptr_nxt       = inc3(r_sel);
                        w_beats_nxt     = '0;
                        w_state_nxt     = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (!nreset) w_ack = 3'b000;
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_sel       <= '0;
            r_beats     <= '0;
            r_cs        <= 1'b0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_sel       <= w_sel_nxt;
            r_beats     <= w_beats_nxt;
            r_cs        <= w_cs_nxt;
            r_out       <= w_out_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

`ifdef MUX_SCHED_STATS_EN
    logic [2:0][CNT_W-1:0] r_grant_cnt;
    logic                  w_grant;

    assign w_grant = (r_state == IDLE) && w_pick_ok;

    // Per-grant saturating counters
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_grant_cnt <= '0;
        end else if (w_grant && (r_grant_cnt[w_pick] != {CNT_W{1'b1}})) begin
            r_grant_cnt[w_pick] <= r_grant_cnt[w_pick] + CNT_W'(1);
        end
    end

    assign bus.grant_cnt = r_grant_cnt;
`else
    assign bus.grant_cnt = '0;
`endif

    assign bus.ack       = w_ack;
    assign bus.sel       = r_sel;
    assign bus.cs        = r_cs;
    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Randomized bench for mux_rr_scheduler against a cycle-level behavioural reference model.
module tb_mux_rr_scheduler;
    localparam int BMAX = 4;
    localparam int NCYC = 3000;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    mux_rr_scheduler_if #(.WIDTH(8)) bus ();

    mux_rr_scheduler #(.WIDTH(8), .BURST_MAX(BMAX)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model state
    bit         m_busy;
    int         m_ptr, m_sel, m_beats;
    logic [7:0] m_out;
    bit         m_ov, m_cs;
    int         m_cnt [3];
    logic [2:0] exp_ack;

    // Stimulus staged for the coming cycle
    logic [2:0] s_req;
    logic [7:0] s_data [3];
    logic       s_ready;
    logic       s_nrst;
    int         mode;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Expected combinational ack for the current inputs and model state
    task automatic model_ack(output logic [2:0] a, output int g);
        a = 3'b000;
        g = -1;
        if (s_nrst) begin
            if (!m_busy) begin
                for (int k = 0; k < 3; k++) begin
                    if (g < 0 && s_req[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
                end
                if (g >= 0) a = 3'(1 << g);
            end else if (m_ov && s_ready && s_req[m_sel] && m_beats < BMAX) begin
                g = m_sel;
                a = 3'(1 << g);
            end
        end
    endtask

    task automatic model_step(input int g);
        if (!s_nrst) begin
            m_busy = 0; m_ptr = 0; m_sel = 0; m_beats = 0;
            m_out = 8'h00; m_ov = 0; m_cs = 0;
            for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        end else if (!m_busy) begin
            m_ov = 0; m_cs = 0;
            if (g >= 0) begin
                m_busy = 1; m_sel = g; m_beats = 1;
                m_out = s_data[g]; m_ov = 1; m_cs = 1;
                if (m_cnt[g] < 65535) m_cnt[g] = m_cnt[g] + 1;
            end
        end else if (m_ov && s_ready) begin
            if (g >= 0) begin
                m_out = s_data[g];
                m_beats = m_beats + 1;
            end else begin
                m_busy = 0; m_ov = 0; m_cs = 0; m_beats = 0;
                m_ptr = (m_sel + 1) % 3;
            end
        end
    endtask

    function automatic logic [47:0] exp_cnt();
`ifdef MUX_SCHED_STATS_EN
        return {16'(m_cnt[2]), 16'(m_cnt[1]), 16'(m_cnt[0])};
`else
        return 48'h0;
`endif
    endfunction

    task automatic apply_inputs();
        nreset        = s_nrst;
        bus.req       = s_req;
        bus.alpha     = s_data[0];
        bus.beta      = s_data[1];
        bus.gamma     = s_data[2];
        bus.out_ready = s_ready;
    endtask

    initial begin
        int g;
        int nxt;
        m_busy = 0; m_ptr = 0; m_sel = 0; m_beats = 0;
        m_out = 8'h00; m_ov = 0; m_cs = 0;
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        mode    = 0;
        s_nrst  = 1'b0;
        s_req   = 3'b111;
        s_ready = 1'b1;
        for (int i = 0; i < 3; i++) s_data[i] = 8'($urandom);
        apply_inputs();

        for (cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            apply_inputs();
            #3;
            model_ack(exp_ack, g);
            check("ack",       64'(bus.ack),       64'(exp_ack));
            check("sel",       64'(bus.sel),       64'(m_sel));
            check("cs",        64'(bus.cs),        64'(m_cs));
            check("out",       64'(bus.out),       64'(m_out));
            check("out_valid", 64'(bus.out_valid), 64'(m_ov));
            check("grant_cnt", 64'(bus.grant_cnt), 64'(exp_cnt()));
            model_step(g);

            // Stage the next cycle: sources hold req/data until acked
            nxt = cyc + 1;
            if (nxt == 1500) begin
                mode     = 1;
                s_req    = 3'b001;
                s_data[0] = 8'd1;
            end else if (nxt == 1541) begin
                mode = 0;
            end
            s_nrst = !(nxt < 2 || nxt == 1500 ||
                       (nxt > 2 && mode == 0 && $urandom_range(199) == 0));
            if (mode == 1) begin
                if (nxt > 1500 && exp_ack[0]) s_data[0] = s_data[0] + 8'd1;
                s_req   = 3'b001;
                s_ready = 1'b1;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (exp_ack[i]) begin
                        s_req[i]  = ($urandom_range(3) != 0);
                        s_data[i] = 8'($urandom);
                    end else if (!s_req[i] && $urandom_range(9) < 3) begin
                        s_req[i]  = 1'b1;
                        s_data[i] = 8'($urandom);
                    end
                end
                s_ready = ($urandom_range(9) < 7);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
